// File: rtl/video_timing_monitor.sv
// Per-frame raster measurement (h/v total and active) with a lock detector
// that reports stable timing and pulses mode_change when a lock is lost.
module video_timing_monitor #(
    parameter int CNT_W         = 12,
    parameter int STABLE_FRAMES = 3
) (
    input  logic             clk_vid,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    output logic [CNT_W-1:0] htotal,
    output logic [CNT_W-1:0] hactive,
    output logic [CNT_W-1:0] vtotal,
    output logic [CNT_W-1:0] vactive,
    output logic             valid,
    output logic             stable,
    output logic             mode_change
);
    // state   | meaning
    // IDLE    | after reset/timeout; next vs rise ends a partial frame
    // MEASURE | waiting for a clean frame record
    // CONFIRM | outputs loaded, counting consecutive matching frames
    // LOCKED  | timing stable; any differing frame drops the lock
    typedef enum logic [1:0] {IDLE, MEASURE, CONFIRM, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       STABLE_N  = 4'(STABLE_FRAMES);
    localparam bit               ONE_FRAME = (STABLE_FRAMES <= 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic             hs_q, vs_q;
    logic [CNT_W-1:0] pix_cnt, de_cnt, line_cnt, act_cnt, h_len, h_act;
    logic             hs_rise, vs_rise;
    logic [CNT_W-1:0] line_nx, act_nx, h_len_nx, h_act_nx;
    logic             f_err, f_eq;

    assign hs_rise = ce_pix & hs & ~hs_q;
    assign vs_rise = ce_pix & vs & ~vs_q;

    // Frame record sees the hs update of a coincident hs/vs rise
    assign line_nx  = hs_rise ? sat_inc(line_cnt) : line_cnt;
    assign act_nx   = (hs_rise && de_cnt != '0) ? sat_inc(act_cnt) : act_cnt;
    assign h_len_nx = hs_rise ? pix_cnt : h_len;
    assign h_act_nx = (hs_rise && de_cnt != '0) ? de_cnt : h_act;

    assign f_err = (h_len_nx == CNT_MAX) || (h_act_nx == CNT_MAX) ||
                   (line_nx == CNT_MAX) || (act_nx == CNT_MAX) || (line_nx == '0);
    assign f_eq  = (h_len_nx == htotal) && (h_act_nx == hactive) &&
                   (line_nx == vtotal) && (act_nx == vactive);

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            pix_cnt  <= '0;
            de_cnt   <= '0;
            line_cnt <= '0;
            act_cnt  <= '0;
            h_len    <= '0;
            h_act    <= '0;
        end else if (ce_pix) begin
            hs_q     <= hs;
            vs_q     <= vs;
            pix_cnt  <= hs_rise ? CNT_W'(1) : sat_inc(pix_cnt);
            de_cnt   <= hs_rise ? '0 : (de ? sat_inc(de_cnt) : de_cnt);
            h_len    <= h_len_nx;
            h_act    <= h_act_nx;
            line_cnt <= vs_rise ? '0 : line_nx;
            act_cnt  <= vs_rise ? '0 : act_nx;
        end
    end

    state_t           state, state_n;
    logic [3:0]       mcnt, mcnt_n, mcnt_inc;
    logic [CNT_W-1:0] htotal_n, hactive_n, vtotal_n, vactive_n;
    logic             valid_n, stable_n, mc_n, confirm;

    assign mcnt_inc = mcnt + 4'd1;

    always_comb begin
        state_n   = state;
        mcnt_n    = mcnt;
        htotal_n  = htotal;
        hactive_n = hactive;
        vtotal_n  = vtotal;
        vactive_n = vactive;
        valid_n   = valid;
        stable_n  = stable;
        mc_n      = 1'b0;
        confirm   = 1'b0;
        if (state != IDLE && ce_pix && line_cnt == CNT_MAX) begin
            mc_n     = stable;
            valid_n  = 1'b0;
            stable_n = 1'b0;
            state_n  = IDLE;
        end else if (vs_rise) begin
            case (state)
                IDLE:    state_n = MEASURE;
                MEASURE: begin
                    if (!f_err) begin
                        htotal_n  = h_len_nx;
                        hactive_n = h_act_nx;
                        vtotal_n  = line_nx;
                        vactive_n = act_nx;
                        valid_n   = 1'b1;
                        mcnt_n    = 4'd1;
                        stable_n  = ONE_FRAME;
                        state_n   = ONE_FRAME ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: confirm = 1'b1;
                LOCKED: begin
                    if (!f_eq) begin
                        mc_n     = 1'b1;
                        stable_n = 1'b0;
                        confirm  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (confirm) begin
                if (f_eq) begin
                    mcnt_n = mcnt_inc;
                    if (mcnt_inc >= STABLE_N) begin
                        stable_n = 1'b1;
                        state_n  = LOCKED;
                    end else begin
                        state_n = CONFIRM;
                    end
                end else if (!f_err) begin
                    htotal_n  = h_len_nx;
                    hactive_n = h_act_nx;
                    vtotal_n  = line_nx;
                    vactive_n = act_nx;
                    mcnt_n    = 4'd1;
                    stable_n  = ONE_FRAME;
                    state_n   = ONE_FRAME ? LOCKED : CONFIRM;
                end else begin
                    valid_n  = 1'b0;
                    stable_n = 1'b0;
                    state_n  = MEASURE;
                end
            end
        end
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mcnt        <= '0;
            htotal      <= '0;
            hactive     <= '0;
            vtotal      <= '0;
            vactive     <= '0;
            valid       <= 1'b0;
            stable      <= 1'b0;
            mode_change <= 1'b0;
        end else begin
            state       <= state_n;
            mcnt        <= mcnt_n;
            htotal      <= htotal_n;
            hactive     <= hactive_n;
            vtotal      <= vtotal_n;
            vactive     <= vactive_n;
            valid       <= valid_n;
            stable      <= stable_n;
            mode_change <= mc_n;
        end
    end
endmodule

// File: tb/tb_video_timing_monitor.sv
// Self-checking bench for video_timing_monitor using scaled-down rasters
// (30x20 total / 20x15 active and 36x22 / 24x16) to keep run time short.
module tb_video_timing_monitor;
    logic        clk_vid = 1'b0;
    logic        reset, ce_pix, hs, vs, de;
    logic [11:0] htotal, hactive, vtotal, vactive;
    logic        valid, stable, mode_change;

    video_timing_monitor #(.CNT_W(12), .STABLE_FRAMES(3)) dut (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .hs(hs), .vs(vs), .de(de),
        .htotal(htotal), .hactive(hactive), .vtotal(vtotal), .vactive(vactive),
        .valid(valid), .stable(stable), .mode_change(mode_change)
    );

    always #5 clk_vid = ~clk_vid;

    typedef struct {
        int act;      // 0 none, 1 timeout before row, 2 mid-frame reset before row
        int hto, hact, vto, vact, div;
        bit coin;     // vs rises on the same pixel as hs
        bit ev, es, emc, cv;
        int eht, eha, evt, eva;
    } vec_t;

    typedef struct {
        bit v, s, mc, cv;
        int ht, ha, vt, va;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[24];
    int   checks = 0;
    int   errors = 0;
    int   mc_seen = 0;
    bit   mc_pend = 1'b0;

    always @(negedge clk_vid) if (mode_change === 1'b1) mc_seen++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit h, input bit v, input bit d, input bit c);
        hs = h; vs = v; de = d; ce_pix = c;
        @(posedge clk_vid);
        #1;
        if (mc_pend) begin
            chk("mode_change_width", int'(mode_change), 0);
            mc_pend = 1'b0;
        end
    endtask

    task automatic pix(input bit h, input bit v, input bit d, input int div, input bit vsr);
        logic [50:0] snap;
        exp_t        e;
        snap = {htotal, hactive, vtotal, vactive, valid, stable, mode_change};
        for (int c = 0; c < div - 1; c++) cyc(h, v, d, 1'b0);
        if (vsr && div > 1)
            chk("ce0_hold", int'(snap == {htotal, hactive, vtotal, vactive, valid, stable, mode_change}), 1);
        cyc(h, v, d, 1'b1);
        if (vsr) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("valid", int'(valid), int'(e.v));
                chk("stable", int'(stable), int'(e.s));
                chk("mode_change", int'(mode_change), int'(e.mc));
                if (e.cv) begin
                    chk("htotal", int'(htotal), e.ht);
                    chk("hactive", int'(hactive), e.ha);
                    chk("vtotal", int'(vtotal), e.vt);
                    chk("vactive", int'(vactive), e.va);
                end
                if (e.mc) mc_pend = 1'b1;
            end
        end
    endtask

    task automatic raster_line(input int hto, input int hact, input int vact, input int l);
        for (int p = 0; p < hto; p++)
            pix(p >= hact + 2 && p < hact + 5, 1'b0, l < vact && p < hact, 1, 1'b0);
    endtask

    task automatic run_row(input vec_t v);
        int   hss, vsx;
        bit   h, vv, d, vsr;
        exp_t e;
        hss = v.hact + 2;
        vsx = v.coin ? hss : 0;
        for (int l = 0; l < v.vto; l++) begin
            for (int p = 0; p < v.hto; p++) begin
                h   = (p >= hss && p < hss + 3);
                vv  = (l == 0 && p >= vsx) || (l == 1) || (l == 2 && p < vsx);
                d   = (l < v.vact && p < v.hact);
                vsr = (l == 0 && p == vsx);
                if (vsr) begin
                    e.v = v.ev; e.s = v.es; e.mc = v.emc; e.cv = v.cv;
                    e.ht = v.eht; e.ha = v.eha; e.vt = v.evt; e.va = v.eva;
                    sb.push_back(e);
                end
                pix(h, vv, d, v.div, vsr);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_htotal"}, int'(htotal), 0);
        chk({tag, "_hactive"}, int'(hactive), 0);
        chk({tag, "_vtotal"}, int'(vtotal), 0);
        chk({tag, "_vactive"}, int'(vactive), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_stable"}, int'(stable), 0);
        chk({tag, "_mode_change"}, int'(mode_change), 0);
    endtask

    // r: 0 raster A, 1 raster B; er: expected values 0 zeros, 1 A, 2 B
    function automatic vec_t mk(input int act, input int r, input int div, input bit coin,
                                input bit ev, input bit es, input bit emc, input bit cv,
                                input int er);
        vec_t v;
        v.act = act; v.div = div; v.coin = coin;
        v.ev = ev; v.es = es; v.emc = emc; v.cv = cv;
        if (r == 0) begin v.hto = 30; v.hact = 20; v.vto = 20; v.vact = 15; end
        else        begin v.hto = 36; v.hact = 24; v.vto = 22; v.vact = 16; end
        case (er)
            1:       begin v.eht = 30; v.eha = 20; v.evt = 20; v.eva = 15; end
            2:       begin v.eht = 36; v.eha = 24; v.evt = 22; v.eva = 16; end
            default: begin v.eht = 0;  v.eha = 0;  v.evt = 0;  v.eva = 0;  end
        endcase
        return v;
    endfunction

    initial begin
        int mc_before;
        tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[2]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[3]  = mk(0, 0, 1, 0, 1, 1, 0, 1, 1);
        tbl[4]  = mk(0, 1, 1, 0, 1, 1, 0, 1, 1);
        tbl[5]  = mk(0, 1, 1, 0, 1, 0, 1, 1, 2);
        tbl[6]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 2);
        tbl[7]  = mk(0, 1, 1, 0, 1, 1, 0, 1, 2);
        tbl[8]  = mk(0, 0, 4, 0, 1, 1, 0, 1, 2);
        tbl[9]  = mk(0, 0, 4, 0, 1, 0, 1, 1, 1);
        tbl[10] = mk(0, 0, 4, 0, 1, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 4, 0, 1, 1, 0, 1, 1);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[15] = mk(0, 0, 1, 0, 1, 1, 0, 1, 1);
        tbl[16] = mk(2, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[18] = mk(0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[19] = mk(0, 0, 1, 0, 1, 1, 0, 1, 1);
        tbl[20] = mk(2, 0, 1, 1, 0, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 1, 1, 1, 0, 0, 1, 1);
        tbl[22] = mk(0, 0, 1, 1, 1, 0, 0, 1, 1);
        tbl[23] = mk(0, 0, 1, 1, 1, 1, 0, 1, 1);

        reset = 1'b1; ce_pix = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (3) @(posedge clk_vid);
        #1;
        check_zero("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].act == 1) begin
                // vs held low while hs keeps running: line counter saturates
                mc_before = mc_seen;
                for (int l = 0; l < 4100; l++)
                    for (int p = 0; p < 4; p++) pix(p == 0, 1'b0, 1'b0, 1, 1'b0);
                chk("timeout_valid", int'(valid), 0);
                chk("timeout_stable", int'(stable), 0);
                chk("timeout_mc_pulses", mc_seen - mc_before, 1);
            end else if (tbl[i].act == 2) begin
                for (int l = 5; l < 10; l++) raster_line(30, 20, 15, l);
                reset = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; ce_pix = 1'b1;
                #1;
                check_zero("midframe_reset");
                @(posedge clk_vid); #1;
                @(posedge clk_vid); #1;
                reset = 1'b0;
            end
            run_row(tbl[i]);
        end

        chk("scoreboard_drained", sb.size(), 0);
        chk("mode_change_total", mc_seen, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
